// File: rtl/pmem_arbiter_if.sv
// Bundle of every signal between the two caches, the arbiter and physical memory.
// The arbiter takes the slave view; the cache/memory side takes the master view.
interface pmem_arbiter_if;
   logic         i_pmem_read;
   logic [15:0]  i_pmem_address;
   logic [127:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic         d_pmem_read;
   logic         d_pmem_write;
   logic [15:0]  d_pmem_address;
   logic [127:0] d_pmem_wdata;
   logic [127:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   logic         i_grant;
   logic         d_grant;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  pmem_rdata, pmem_resp,
      output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      output i_grant, d_grant
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output pmem_rdata, pmem_resp,
      input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  i_grant, d_grant
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// Strobes and responses pass through combinationally from the registered grant state.
module pmem_arbiter (
   input  logic          clk,
   input  logic          reset,
   pmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t state_r;
   logic   last_d_r;
   logic   i_req_s;
   logic   d_req_s;

   assign i_req_s = bus.i_pmem_read;
   assign d_req_s = bus.d_pmem_read | bus.d_pmem_write;

   // Grant FSM; last_d_r remembers the most recent owner so ties alternate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         last_d_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_req_s && (!d_req_s || last_d_r)) begin
                  state_r  <= SERVE_I;
                  last_d_r <= 1'b0;
               end else if (d_req_s) begin
                  state_r  <= SERVE_D;
                  last_d_r <= 1'b1;
               end else begin
                  state_r  <= IDLE;
               end
            end
            // A dropped request abandons the grant just like a completion does.
            SERVE_I: begin
               if (bus.pmem_resp || !i_req_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= SERVE_I;
               end
            end
            SERVE_D: begin
               if (bus.pmem_resp || !d_req_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= SERVE_D;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Route the owner's request to memory and memory's completion back to the owner.
   always_comb begin
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = 16'h0000;
      bus.i_pmem_resp  = 1'b0;
      bus.d_pmem_resp  = 1'b0;
      case (state_r)
         SERVE_I: begin
            bus.pmem_read    = bus.i_pmem_read;
            bus.pmem_address = bus.i_pmem_address;
            bus.i_pmem_resp  = bus.pmem_resp & i_req_s;
         end
         SERVE_D: begin
            bus.pmem_read    = bus.d_pmem_read;
            bus.pmem_write   = bus.d_pmem_write;
            bus.pmem_address = bus.d_pmem_address;
            bus.d_pmem_resp  = bus.pmem_resp & d_req_s;
         end
         default: begin
            bus.pmem_read    = 1'b0;
            bus.pmem_write   = 1'b0;
            bus.pmem_address = 16'h0000;
         end
      endcase
   end

   assign bus.i_grant      = (state_r == SERVE_I);
   assign bus.d_grant      = (state_r == SERVE_D);
   assign bus.i_pmem_rdata = bus.pmem_rdata;
   assign bus.d_pmem_rdata = bus.pmem_rdata;
   assign bus.pmem_wdata   = bus.d_pmem_wdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter; inputs change 2 ns after the
// rising edge and outputs are compared 1 ns later.
module tb_pmem_arbiter;

   logic clk;
   logic reset;
   int   check_cnt;
   int   error_cnt;

   pmem_arbiter_if bus ();

   pmem_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      check_cnt++;
      if (got !== exp) begin
         error_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_rd"},    128'(bus.pmem_read),    128'd0);
      check_val({tag, "_wr"},    128'(bus.pmem_write),   128'd0);
      check_val({tag, "_addr"},  128'(bus.pmem_address), 128'd0);
      check_val({tag, "_gnt"},   128'({bus.i_grant, bus.d_grant}), 128'd0);
      check_val({tag, "_resp"},  128'({bus.i_pmem_resp, bus.d_pmem_resp}), 128'd0);
   endtask

   // In a granted cycle: check strobes, then pulse pmem_resp and check routing.
   task automatic check_serve(input string tag, input logic is_d, input logic [15:0] addr,
                              input logic rd, input logic wr);
      check_val({tag, "_igrant"}, 128'(bus.i_grant), 128'(!is_d));
      check_val({tag, "_dgrant"}, 128'(bus.d_grant), 128'(is_d));
      check_val({tag, "_rd"},     128'(bus.pmem_read),  128'(rd));
      check_val({tag, "_wr"},     128'(bus.pmem_write), 128'(wr));
      check_val({tag, "_addr"},   128'(bus.pmem_address), 128'(addr));
      bus.pmem_resp = 1'b1;
      settle();
      check_val({tag, "_iresp"},  128'(bus.i_pmem_resp), 128'(!is_d));
      check_val({tag, "_dresp"},  128'(bus.d_pmem_resp), 128'(is_d));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      settle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] line_a5;
      check_cnt = 0;
      error_cnt = 0;
      line_a5   = {16{8'hA5}};
      reset     = 1'b1;
      bus.i_pmem_read    = 1'b0;
      bus.i_pmem_address = 16'h0000;
      bus.d_pmem_read    = 1'b0;
      bus.d_pmem_write   = 1'b0;
      bus.d_pmem_address = 16'h0000;
      bus.d_pmem_wdata   = 128'd0;
      bus.pmem_rdata     = 128'd0;
      bus.pmem_resp      = 1'b0;

      // Reset state, plus stray requests ignored while reset is held
      step();
      bus.i_pmem_read = 1'b1;
      bus.d_pmem_write = 1'b1;
      bus.i_pmem_address = 16'h1111;
      settle();
      check_idle("rst");
      step();
      settle();
      check_idle("rst_hold");
      bus.i_pmem_read = 1'b0;
      bus.d_pmem_write = 1'b0;
      do_reset();

      // Single I read with 3-cycle memory latency
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h1230;
      settle();
      check_val("t1_lat0", 128'(bus.pmem_read), 128'd0);
      step();
      settle();
      check_val("t1_strobe", 128'(bus.pmem_read), 128'd1);
      check_val("t1_addr", 128'(bus.pmem_address), 128'h1230);
      step();
      step();
      settle();
      check_val("t1_noresp", 128'(bus.i_pmem_resp), 128'd0);
      step();
      bus.pmem_rdata = line_a5;
      check_serve("t1", 1'b0, 16'h1230, 1'b1, 1'b0);
      check_val("t1_irdata", bus.i_pmem_rdata, line_a5);
      check_val("t1_drdata", bus.d_pmem_rdata, line_a5);
      step();
      bus.pmem_resp   = 1'b0;
      bus.i_pmem_read = 1'b0;
      settle();
      check_idle("t1_end");

      // Simultaneous I read and D write after reset: D first, then I
      do_reset();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h0040;
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 16'h0080;
      bus.d_pmem_wdata   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      settle();
      check_val("t2_wdata", bus.pmem_wdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      step();
      check_serve("t2_d", 1'b1, 16'h0080, 1'b0, 1'b1);
      step();
      bus.pmem_resp    = 1'b0;
      bus.d_pmem_write = 1'b0;
      settle();
      check_idle("t2_turn");
      step();
      check_serve("t2_i", 1'b0, 16'h0040, 1'b1, 1'b0);
      step();
      bus.pmem_resp   = 1'b0;
      bus.i_pmem_read = 1'b0;

      // Continuous contention: strict D,I alternation with one idle cycle between
      do_reset();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h0300;
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_address = 16'h0400;
      for (int t = 0; t < 6; t++) begin
         logic exp_d;
         exp_d = (t % 2 == 0);
         step();
         check_serve($sformatf("t3_%0d", t), exp_d, exp_d ? 16'h0400 : 16'h0300, 1'b1, 1'b0);
         step();
         bus.pmem_resp = 1'b0;
         settle();
         check_idle($sformatf("t3_turn%0d", t));
      end
      bus.i_pmem_read = 1'b0;
      bus.d_pmem_read = 1'b0;

      // D write-back, then D fill, with I pending: D-write, I-read, D-read
      do_reset();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h0200;
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 16'h0100;
      step();
      check_serve("t4_dw", 1'b1, 16'h0100, 1'b0, 1'b1);
      step();
      bus.pmem_resp    = 1'b0;
      bus.d_pmem_write = 1'b0;
      bus.d_pmem_read  = 1'b1;
      step();
      check_serve("t4_ir", 1'b0, 16'h0200, 1'b1, 1'b0);
      step();
      bus.pmem_resp   = 1'b0;
      bus.i_pmem_read = 1'b0;
      step();
      check_serve("t4_dr", 1'b1, 16'h0100, 1'b1, 1'b0);
      step();
      bus.pmem_resp   = 1'b0;
      bus.d_pmem_read = 1'b0;

      // Reset mid-SERVE_D: write strobe drops with no clock edge
      do_reset();
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 16'h0500;
      step();
      settle();
      check_val("t5_wr", 128'(bus.pmem_write), 128'd1);
      reset = 1'b1;
      #1;
      check_val("t5_wr_drop", 128'(bus.pmem_write), 128'd0);
      check_val("t5_addr", 128'(bus.pmem_address), 128'd0);
      bus.pmem_resp = 1'b1;
      #1;
      check_val("t5_noresp", 128'(bus.d_pmem_resp), 128'd0);
      bus.pmem_resp    = 1'b0;
      bus.d_pmem_write = 1'b0;
      step();
      reset = 1'b0;
      step();
      settle();
      check_idle("t5_idle");

      // Granted I drops its request; waiting D is granted afterwards
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h0600;
      step();
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_address = 16'h0700;
      settle();
      check_val("t6_rd", 128'(bus.pmem_read), 128'd1);
      check_val("t6_addr", 128'(bus.pmem_address), 128'h0600);
      bus.i_pmem_read = 1'b0;
      settle();
      check_val("t6_rd_drop", 128'(bus.pmem_read), 128'd0);
      check_val("t6_noresp", 128'(bus.i_pmem_resp), 128'd0);
      step();
      settle();
      check_idle("t6_idle");
      step();
      check_serve("t6_d", 1'b1, 16'h0700, 1'b1, 1'b0);
      step();
      bus.pmem_resp   = 1'b0;
      bus.d_pmem_read = 1'b0;
      settle();

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
      $finish;
   end

endmodule
